// File: rtl/im_prefetch_if.sv
// Fetch-side bundle of the prefetching instruction memory: redirect, IF handshake and
// program-load port.
interface im_prefetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [31:0]       out_pc;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;

  // Core / loader side
  modport master (
    output redirect_valid, redirect_pc, out_ready, load_en, load_addr, load_data,
    input  out_valid, out_instr, out_pc, busy
  );

  // Memory / prefetch side
  modport slave (
    input  redirect_valid, redirect_pc, out_ready, load_en, load_addr, load_data,
    output out_valid, out_instr, out_pc, busy
  );
endinterface

// File: rtl/im_prefetch.sv
// Instruction memory with a registered read port and a sequential prefetch FIFO feeding
// the IF stage over valid/ready; redirect flushes and restarts fetch.
module im_prefetch #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rstn,
  im_prefetch_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Fetch engine state
  logic [31:0]       fpc_q, fpc_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [31:0]       rd_tag_q;

  // Prefetch FIFO
  logic [DATA_W-1:0] fifo_instr [DEPTH];
  logic [31:0]       fifo_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] fetch_idx;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  always_comb begin
    head_valid = (count_q != '0);
    fetch_idx  = fpc_q[ADDR_W+1:2];
    // Credit counts the in-flight read so a push always finds a free slot.
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue      = !bus.load_en && !bus.redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
    push       = inflight_q && !bus.redirect_valid;
    pop        = head_valid && bus.out_ready && !bus.redirect_valid;
  end

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fpc_d    = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Memory array and read register; issue is never asserted on a load edge.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
    if (issue) begin
      rd_data_q <= mem[fetch_idx];
      rd_tag_q  <= fpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= rd_data_q;
      fifo_pc[wr_ptr_q]    <= rd_tag_q;
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_valid ? fifo_instr[rd_ptr_q] : '0;
  assign bus.out_pc    = head_valid ? fifo_pc[rd_ptr_q] : '0;
  assign bus.busy      = inflight_q || head_valid;

endmodule
